// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between two requesters: grant, execute, return result.
// Build option: define ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties).
//
// state  | meaning
// IDLE   | waiting for a request; grant and latch operands combinationally
// EXEC   | ALU driven from latched operands; result captured on the edge
// RESP   | result presented to the granted requester until consumed
module alu_share_arbiter #(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [2*DATA_W-1:0] req_op1,
  input  logic [2*DATA_W-1:0] req_op2,
  input  logic [5:0]          req_funct3,
  input  logic [13:0]         req_funct7,
  input  logic [9:0]          req_shamt,
  input  logic [5:0]          req_type,
  output logic [1:0]          resp_valid,
  input  logic [1:0]          resp_ready,
  output logic [DATA_W-1:0]   resp_result,
  output logic [DATA_W-1:0]   alu_op1,
  output logic [DATA_W-1:0]   alu_op2,
  output logic [2:0]          alu_funct3,
  output logic [6:0]          alu_funct7,
  output logic [4:0]          alu_shamt,
  output logic [2:0]          alu_insn_type,
  input  logic [DATA_W-1:0]   alu_result,
  output logic                busy,
  output logic                grant_id
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_RESP = 2'b10
  } state_t;

  state_t state;
  logic   winner;
  logic   grant;

`ifdef ARB_FIXED_PRIO_EN
  assign winner = ~req_valid[0];
`else
  logic rr;
  // On a tie the preferred requester wins; otherwise the lone valid one does.
  assign winner = (&req_valid) ? rr : req_valid[1];
`endif

  assign grant     = (state == S_IDLE) && (|req_valid);
  assign req_ready = grant ? (winner ? 2'b10 : 2'b01) : 2'b00;
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
`ifndef ARB_FIXED_PRIO_EN
      rr            <= 1'b0;
`endif
      grant_id      <= 1'b0;
      resp_valid    <= 2'b00;
      resp_result   <= '0;
      alu_op1       <= '0;
      alu_op2       <= '0;
      alu_funct3    <= 3'b000;
      alu_funct7    <= 7'b0000000;
      alu_shamt     <= 5'b00000;
      alu_insn_type <= 3'b100;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant) begin
            alu_op1       <= winner ? req_op1[DATA_W +: DATA_W] : req_op1[0 +: DATA_W];
            alu_op2       <= winner ? req_op2[DATA_W +: DATA_W] : req_op2[0 +: DATA_W];
            alu_funct3    <= winner ? req_funct3[5:3]  : req_funct3[2:0];
            alu_funct7    <= winner ? req_funct7[13:7] : req_funct7[6:0];
            alu_shamt     <= winner ? req_shamt[9:5]   : req_shamt[4:0];
            alu_insn_type <= winner ? req_type[5:3]    : req_type[2:0];
            grant_id      <= winner;
`ifndef ARB_FIXED_PRIO_EN
            rr            <= ~winner;
`endif
            state         <= S_EXEC;
          end
        end
        S_EXEC: begin
          resp_result <= alu_result;
          resp_valid  <= grant_id ? 2'b10 : 2'b01;
          state       <= S_RESP;
        end
        S_RESP: begin
          if (resp_ready[grant_id]) begin
            resp_valid <= 2'b00;
            state      <= S_IDLE;
          end
        end
        default: begin
          resp_valid <= 2'b00;
          state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a small stand-in ALU model.
module tb_alu_share_arbiter;

  localparam int DATA_W = 32;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [1:0]          req_valid = '0;
  logic [1:0]          req_ready;
  logic [2*DATA_W-1:0] req_op1 = '0;
  logic [2*DATA_W-1:0] req_op2 = '0;
  logic [5:0]          req_funct3 = '0;
  logic [13:0]         req_funct7 = '0;
  logic [9:0]          req_shamt = '0;
  logic [5:0]          req_type = '0;
  logic [1:0]          resp_valid;
  logic [1:0]          resp_ready = '0;
  logic [DATA_W-1:0]   resp_result;
  logic [DATA_W-1:0]   alu_op1, alu_op2;
  logic [2:0]          alu_funct3;
  logic [6:0]          alu_funct7;
  logic [4:0]          alu_shamt;
  logic [2:0]          alu_insn_type;
  logic [DATA_W-1:0]   alu_result;
  logic                busy;
  logic                grant_id;

  int vectors = 0;
  int miscompares = 0;

  alu_share_arbiter #(.DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op1(req_op1), .req_op2(req_op2),
    .req_funct3(req_funct3), .req_funct7(req_funct7),
    .req_shamt(req_shamt), .req_type(req_type),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_funct3(alu_funct3),
    .alu_funct7(alu_funct7), .alu_shamt(alu_shamt), .alu_insn_type(alu_insn_type),
    .alu_result(alu_result), .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] f3, input logic [6:0] f7,
                                            input logic [4:0] sh, input logic [2:0] ty);
    logic [31:0] r;
    r = 32'h0;
    if (ty == 3'b000) begin
      if (f3 == 3'b000) r = a + b;
      else if (f3 == 3'b101) r = f7[5] ? 32'($signed(a) >>> sh) : a >> sh;
    end else if (ty == 3'b001) begin
      if (f3 == 3'b000) r = f7[5] ? a - b : a + b;
      else if (f3 == 3'b101) r = f7[5] ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
    end
    return r;
  endfunction

  assign alu_result = alu_model(alu_op1, alu_op2, alu_funct3, alu_funct7, alu_shamt, alu_insn_type);

  task automatic set_bundle(input int i, input logic [31:0] a, input logic [31:0] b,
                            input logic [2:0] f3, input logic [6:0] f7,
                            input logic [4:0] sh, input logic [2:0] ty);
    req_op1[i*32 +: 32] = a;
    req_op2[i*32 +: 32] = b;
    req_funct3[i*3 +: 3] = f3;
    req_funct7[i*7 +: 7] = f7;
    req_shamt[i*5 +: 5] = sh;
    req_type[i*3 +: 3] = ty;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
    vectors++; if (grant_id !== 1'b0) begin miscompares++; $display("FAIL reset_grant_id got %b want 0", grant_id); end
    vectors++; if (resp_valid !== 2'b00) begin miscompares++; $display("FAIL reset_resp_valid got %b want 00", resp_valid); end
    vectors++; if (req_ready !== 2'b00) begin miscompares++; $display("FAIL reset_req_ready got %b want 00", req_ready); end
    vectors++; if (resp_result !== 32'h0) begin miscompares++; $display("FAIL reset_resp_result got %h want 0", resp_result); end
    vectors++; if ({alu_op1, alu_op2} !== 64'h0) begin miscompares++; $display("FAIL reset_alu_ops got %h/%h want 0/0", alu_op1, alu_op2); end
    vectors++; if ({alu_funct3, alu_funct7, alu_shamt, alu_insn_type} !== {3'b000, 7'b0, 5'b0, 3'b100}) begin
      miscompares++; $display("FAIL reset_alu_ctrl got f3=%b f7=%b sh=%b ty=%b want 000/0000000/00000/100",
                              alu_funct3, alu_funct7, alu_shamt, alu_insn_type); end
    rst = 1'b0;
  endtask

  task automatic test_single(input int id, input logic [31:0] a, input logic [31:0] b,
                             input logic [2:0] f3, input logic [6:0] f7, input logic [2:0] ty,
                             input logic [31:0] exp);
    logic [1:0] oh;
    oh = (id == 1) ? 2'b10 : 2'b01;
    set_bundle(id, a, b, f3, f7, 5'd0, ty);
    req_valid = oh;
    #1;
    vectors++; if (req_ready !== oh) begin miscompares++; $display("FAIL single%0d_req_ready got %b want %b", id, req_ready, oh); end
    step();
    req_valid = 2'b00;
    #1;
    vectors++; if (busy !== 1'b1 || resp_valid !== 2'b00) begin
      miscompares++; $display("FAIL single%0d_exec got busy=%b resp_valid=%b want 1/00", id, busy, resp_valid); end
    vectors++; if (alu_op1 !== a || alu_op2 !== b) begin
      miscompares++; $display("FAIL single%0d_alu_ops got %h/%h want %h/%h", id, alu_op1, alu_op2, a, b); end
    step();
    vectors++; if (resp_valid !== oh) begin miscompares++; $display("FAIL single%0d_resp_valid got %b want %b", id, resp_valid, oh); end
    vectors++; if (resp_result !== exp) begin miscompares++; $display("FAIL single%0d_result got %h want %h", id, resp_result, exp); end
    vectors++; if (grant_id !== id[0]) begin miscompares++; $display("FAIL single%0d_grant_id got %b want %b", id, grant_id, id[0]); end
    resp_ready = oh;
    step();
    vectors++; if (resp_valid !== 2'b00 || busy !== 1'b0) begin
      miscompares++; $display("FAIL single%0d_release got resp_valid=%b busy=%b want 00/0", id, resp_valid, busy); end
    resp_ready = 2'b00;
  endtask

  task automatic test_round_robin();
    logic       exp_id;
    logic [1:0] oh;
    logic [31:0] exp_res;
    set_bundle(0, 32'd1, 32'd2, 3'b000, 7'b0, 5'd0, 3'b000);
    set_bundle(1, 32'd100, 32'd40, 3'b000, 7'b0100000, 5'd0, 3'b001);
    req_valid = 2'b11;
    resp_ready = 2'b11;
    #1;
    for (int k = 0; k < 4; k++) begin
`ifdef ARB_FIXED_PRIO_EN
      exp_id = 1'b0;
`else
      exp_id = k[0];
`endif
      oh = exp_id ? 2'b10 : 2'b01;
      exp_res = exp_id ? 32'd60 : 32'd3;
      vectors++; if (req_ready !== oh) begin miscompares++; $display("FAIL rr_grant%0d got %b want %b", k, req_ready, oh); end
      step();
      step();
      vectors++; if (resp_valid !== oh || resp_result !== exp_res) begin
        miscompares++; $display("FAIL rr_resp%0d got valid=%b result=%h want %b/%h", k, resp_valid, resp_result, oh, exp_res); end
      step();
    end
    req_valid = 2'b00;
    resp_ready = 2'b00;
  endtask

  task automatic test_backpressure();
    set_bundle(0, 32'hFFFF_FFF0, 32'd4, 3'b101, 7'b0100000, 5'd4, 3'b000);
    set_bundle(1, 32'd9, 32'd6, 3'b000, 7'b0, 5'd0, 3'b001);
    req_valid = 2'b11;
    resp_ready = 2'b00;
    #1;
    vectors++; if (req_ready !== 2'b01) begin miscompares++; $display("FAIL bp_grant got %b want 01", req_ready); end
    step();
    step();
    resp_ready = 2'b10;
    for (int c = 0; c < 5; c++) begin
      #1;
      vectors++; if (resp_valid !== 2'b01 || resp_result !== 32'hFFFF_FFFF || req_ready !== 2'b00) begin
        miscompares++; $display("FAIL bp_hold%0d got valid=%b result=%h req_ready=%b want 01/ffffffff/00",
                                c, resp_valid, resp_result, req_ready); end
      vectors++; if (alu_op1 !== 32'hFFFF_FFF0 || alu_shamt !== 5'd4) begin
        miscompares++; $display("FAIL bp_alu_stable%0d got %h/%0d want fffffff0/4", c, alu_op1, alu_shamt); end
      step();
    end
    resp_ready = 2'b01;
    step();
    req_valid = 2'b10;
    #1;
    vectors++; if (req_ready !== 2'b10) begin miscompares++; $display("FAIL bp_next_grant got %b want 10", req_ready); end
    step();
    req_valid = 2'b00;
    resp_ready = 2'b00;
    step();
    vectors++; if (resp_valid !== 2'b10 || resp_result !== 32'd15) begin
      miscompares++; $display("FAIL bp_req1_resp got valid=%b result=%h want 10/0000000f", resp_valid, resp_result); end
    resp_ready = 2'b10;
    step();
    resp_ready = 2'b00;
  endtask

  task automatic test_reset_in_exec();
    set_bundle(0, 32'd1, 32'd2, 3'b000, 7'b0, 5'd0, 3'b000);
    set_bundle(1, 32'd100, 32'd40, 3'b000, 7'b0100000, 5'd0, 3'b001);
    req_valid = 2'b01;
    #1;
    vectors++; if (req_ready !== 2'b01) begin miscompares++; $display("FAIL rst_pre_grant got %b want 01", req_ready); end
    step();
    req_valid = 2'b00;
    resp_ready = 2'b01;
    #2;
    rst = 1'b1;
    #1;
    vectors++; if (busy !== 1'b0 || resp_valid !== 2'b00 || grant_id !== 1'b0) begin
      miscompares++; $display("FAIL rst_async_state got busy=%b resp_valid=%b grant_id=%b want 0/00/0", busy, resp_valid, grant_id); end
    vectors++; if (resp_result !== 32'h0 || alu_op1 !== 32'h0 || alu_op2 !== 32'h0 || alu_insn_type !== 3'b100) begin
      miscompares++; $display("FAIL rst_async_data got result=%h op1=%h op2=%h ty=%b want 0/0/0/100",
                              resp_result, alu_op1, alu_op2, alu_insn_type); end
    for (int c = 0; c < 2; c++) begin
      step();
      vectors++; if (resp_valid !== 2'b00) begin miscompares++; $display("FAIL rst_no_resp%0d got %b want 00", c, resp_valid); end
    end
    rst = 1'b0;
    req_valid = 2'b11;
    #1;
    vectors++; if (req_ready !== 2'b01) begin miscompares++; $display("FAIL rst_first_grant got %b want 01", req_ready); end
    step();
    req_valid = 2'b00;
    step();
    vectors++; if (resp_valid !== 2'b01 || resp_result !== 32'd3) begin
      miscompares++; $display("FAIL rst_post_resp got valid=%b result=%h want 01/00000003", resp_valid, resp_result); end
    step();
    resp_ready = 2'b00;
  endtask

  initial begin
    test_reset();
    step();
    test_single(0, 32'd5, 32'd7, 3'b000, 7'b0, 3'b000, 32'd12);
    test_single(1, 32'd10, 32'd3, 3'b000, 7'b0100000, 3'b001, 32'd7);
    test_round_robin();
    test_backpressure();
    test_reset_in_exec();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t, want completion", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Sequential arbiter that shares the single-cycle combinational ALU between two requesters, for example the execute stage and a load/store address generator. Each request carries a full ALU operand bundle. The block grants one request at a time (round-robin by default), drives the ALU from registered operands, captures the result and returns it over a valid/ready response channel to the granted requester. The block sits between the requesters and the ALU's op1/op2/funct3/funct7/shamt/insn_type inputs and result output.

## Interface
- DATA_W, 32: operand and result width; must match the ALU (32).
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  2  bit i: requester i presents an operation.
- req_ready  out  2  bit i: requester i's operation is accepted this cycle (one-hot or zero).
- req_op1  in  2*DATA_W  requester i's op1 in bits [i*DATA_W +: DATA_W].
- req_op2  in  2*DATA_W  requester i's op2, packed the same way.
- req_funct3  in  6  requester i's funct3 in bits [3i+:3].
- req_funct7  in  14  requester i's funct7 in bits [7i+:7].
- req_shamt  in  10  requester i's shamt in bits [5i+:5].
- req_type  in  6  requester i's insn_type in bits [3i+:3].
- resp_valid  out  2  bit i: result for requester i is valid.
- resp_ready  in  2  bit i: requester i consumes the result.
- resp_result  out  DATA_W  registered ALU result; meaningful only while a resp_valid bit is high.
- alu_op1, alu_op2  out  DATA_W each  operands to the ALU.
- alu_funct3  out  3; alu_funct7  out  7; alu_shamt  out  5; alu_insn_type  out  3  ALU controls.
- alu_result  in  DATA_W  combinational ALU result.
- busy  out  1  high in any state other than IDLE.
- grant_id  out  1  index of the current or most recent grant.

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE**
  - If any req_valid bit is set, pick a winner, assert req_ready[winner] combinationally and latch its bundle into the operand registers. Next state is EXEC.
  - If no req_valid bit is set, stay in IDLE.
- **Round-robin**
  - Pointer rr (1 bit) names the preferred requester.
  - If both requesters are valid, rr wins. If only one is valid, that one wins.
  - On each grant, rr becomes the index of the requester that lost, i.e. ~winner.
- **EXEC**
  - The ALU is driven from the latched registers.
  - On the clock edge, alu_result is captured into resp_result. Next state is RESP.
- **RESP**
  - resp_valid[grant_id] = 1; the other resp_valid bit is 0.
  - Hold while resp_ready[grant_id] = 0. resp_result and all alu_* outputs stay stable.
  - When resp_ready[grant_id] = 1, go to IDLE. The response for a requester is never overtaken by that requester's next grant.
- req_ready is 0 outside IDLE. Requests are not queued; a requester holds req_valid and its bundle until accepted.
- resp_ready on a non-granted bit is ignored.
- alu_* outputs always reflect the operand registers. They change only on a grant.
- The arbiter applies no arithmetic; it is pure transport. Width rules come from the ALU (shamt is 5 bits; register shifts use op2[4:0]).

## Timing
- Accept in cycle T; resp_valid rises at T+2. A response consumed in cycle T+2 returns the FSM to IDLE at T+3, where a new grant can occur.
- Minimum issue interval is 3 cycles per operation.
- Reset values:
  - state = IDLE, rr = 0, grant_id = 0, busy = 0.
  - req_ready = 0 when no request is valid; resp_valid = 0; resp_result = 0.
  - alu_op1 = alu_op2 = 0; alu_funct3 = 0; alu_funct7 = 0; alu_shamt = 0.
  - alu_insn_type = 3'b100, an unused type for which the ALU returns 0.
- Reset asserted in any state forces the reset values immediately (asynchronously). Any in-flight operation and pending response are discarded; no response is ever delivered for them.
- If requests arrive at the same time as reset deassertion, the first grant occurs on the first rising edge with rst low.

## Configuration
- Macro ARB_FIXED_PRIO_EN.
  - Defined: requester 0 always wins when both are valid, and rr is not used.
  - Undefined (default): round-robin as described above.

## Test plan
- After reset, req0 only with op1=5, op2=7, type=000, funct3=000 → req_ready[0] at T, resp_valid[0] at T+2 with result 12, resp_valid[1] = 0.
- req1 only with op1=10, op2=3, type=001, funct3=000, funct7=0100000 → resp_valid[1] at T+2 with result 7, grant_id = 1.
- Both valid continuously for 4 operations, resp_ready = 2'b11 → grant order 0,1,0,1; each response at T+2 of its grant; grants 3 cycles apart.
- Back-pressure: resp_ready[0] = 0 for 5 cycles during RESP with op1=0xFFFFFFF0, op2=4, type=000, funct3=101, funct7=0100000 (SRAI, shamt=4) → resp_valid[0] and result 0xFFFFFFFF held stable, req_ready = 00 throughout, req1 waiting; on release, req1 is granted one cycle later.
- Assert rst during EXEC → outputs take reset values immediately, no resp_valid afterwards, and the next grant after reset goes to requester 0.
- With ARB_FIXED_PRIO_EN defined, both valid continuously for 3 operations → grant order 0,0,0 and req_ready[1] never asserted.
